// File: rtl/axil_irq_responder.sv
// AXI4-Lite register slave for the interrupt example peripheral: four scratch words,
// an interrupt enable mask and a W1C status register fed by synchronized event edges.
module axil_irq_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_IRQ          = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  input  logic [C_NUM_IRQ-1:0]              irq_src,
  output logic                              irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wstate_t;

  wstate_t         wstate;
  logic            aw_held;
  logic            w_held;
  logic [2:0]      waddr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   wstrb_q;
  logic            aw_hs;
  logic            w_hs;
  logic            ar_hs;
  logic            commit;

  logic [DW-1:0]        data_q [4];
  logic [C_NUM_IRQ-1:0] irq_en;
  logic [C_NUM_IRQ-1:0] status;
  logic [C_NUM_IRQ-1:0] sync1;
  logic [C_NUM_IRQ-1:0] sync2;
  logic [C_NUM_IRQ-1:0] sync3;
  logic [C_NUM_IRQ-1:0] rise;

  logic [DW-1:0] strb_mask;
  logic [DW-1:0] en_ext;
  logic [DW-1:0] status_ext;
  logic [DW-1:0] raw_ext;
  logic [DW-1:0] pend_ext;
  logic [DW-1:0] en_merged;
  logic [DW-1:0] data_merged;
  logic [DW-1:0] clr_ext;
  logic [DW-1:0] rd_mux;
  logic          unused_ok;

  assign s_axi_awready = (wstate == W_IDLE) && !aw_held;
  assign s_axi_wready  = (wstate == W_IDLE) && !w_held;
  assign s_axi_arready = !s_axi_rvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = (wstate == W_COMMIT);
  assign rise   = sync2 & ~sync3;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                       s_axi_araddr[1:0], en_merged, clr_ext};

  always_comb begin
    strb_mask  = '0;
    en_ext     = '0;
    status_ext = '0;
    raw_ext    = '0;
    pend_ext   = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      strb_mask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
    en_ext[C_NUM_IRQ-1:0]     = irq_en;
    status_ext[C_NUM_IRQ-1:0] = status;
    raw_ext[C_NUM_IRQ-1:0]    = sync2;
    pend_ext[C_NUM_IRQ-1:0]   = status & irq_en;
    en_merged   = (en_ext & ~strb_mask) | (wdata_q & strb_mask);
    data_merged = (data_q[waddr_q[1:0]] & ~strb_mask) | (wdata_q & strb_mask);
    clr_ext     = (commit && waddr_q == 3'd5) ? (wdata_q & strb_mask) : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[4:2])
      3'd0:    rd_mux = data_q[0];
      3'd1:    rd_mux = data_q[1];
      3'd2:    rd_mux = data_q[2];
      3'd3:    rd_mux = data_q[3];
      3'd4:    rd_mux = en_ext;
      3'd5:    rd_mux = status_ext;
      3'd6:    rd_mux = raw_ext;
      default: rd_mux = pend_ext;
    endcase
  end

  // bvalid is raised on the edge where both halves become held, so the
  // register update lands in the first bvalid cycle (W_COMMIT).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate       <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            waddr_q <= s_axi_awaddr[4:2];
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            wstate       <= W_COMMIT;
            s_axi_bvalid <= 1'b1;
          end
        end
        default: begin
          if (s_axi_bready) begin
            wstate       <= W_IDLE;
            s_axi_bvalid <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
          end else begin
            wstate <= W_RESP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < 4; i++) data_q[i] <= '0;
      irq_en <= '0;
      status <= '0;
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      irq    <= 1'b0;
    end else begin
      if (commit && waddr_q[2] == 1'b0) data_q[waddr_q[1:0]] <= data_merged;
      if (commit && waddr_q == 3'd4) irq_en <= en_merged[C_NUM_IRQ-1:0];
      // set has priority over a same-cycle W1C clear
      status <= (status & ~clr_ext[C_NUM_IRQ-1:0]) | rise;
      sync1  <= irq_src;
      sync2  <= sync1;
      sync3  <= sync2;
      irq    <= |(status & irq_en);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_mux;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_irq_responder.sv
// Directed self-checking bench for axil_irq_responder: register access, strobes,
// split write channels, interrupt event path, W1C races and reset mid-transaction.
module tb_axil_irq_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [3:0]  irq_src;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  axil_irq_responder #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .C_NUM_IRQ(4)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .irq_src(irq_src),
    .irq(irq)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // lat = cycles from the handshake edge until bvalid is seen (1 = next cycle), -1 on timeout
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int lat, output logic [1:0] resp);
    int   n;
    logic aw_done;
    logic w_done;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (s_axi_awvalid && s_axi_awready) aw_done = 1'b1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1'b1;
      tick();
      n++;
      if (aw_done) s_axi_awvalid = 1'b0;
      if (w_done) s_axi_wvalid = 1'b0;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    lat  = s_axi_bvalid ? n + 1 : -1;
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int   n;
    logic done;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      if (s_axi_arready) done = 1'b1;
      tick();
      n++;
    end
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      tick();
      n++;
    end
    lat  = s_axi_rvalid ? n + 1 : -1;
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    ARESET = 1'b1;
    #3;
    tests++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    tests++;
    if ({s_axi_bvalid, s_axi_rvalid, irq} !== 3'b000) begin
      fails++;
      $display("FAIL reset_valid_irq: got %b expected 000", {s_axi_bvalid, s_axi_rvalid, irq});
    end
    tests++;
    if (s_axi_rdata !== 32'h0 || s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
      fails++;
      $display("FAIL reset_rdata_resp: rdata=%h bresp=%b rresp=%b expected 0/00/00",
               s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end
    tick();
    tick();
    @(negedge ACLK);
    ARESET = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), d, r, lat);
      tests++;
      if (d !== 32'h0) begin
        fails++;
        $display("FAIL reset_reg%0d: got %h expected 00000000", i, d);
      end
    end
  endtask

  task automatic test_data_rw();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, lat, r);
      tests++;
      if (lat !== 1 || r !== 2'b00) begin
        fails++;
        $display("FAIL data_write%0d: bvalid latency %0d bresp %b expected 1 / 00", i, lat, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r, lat);
      tests++;
      if (d !== 32'(i + 1) || r !== 2'b00 || lat !== 1) begin
        fails++;
        $display("FAIL data_read%0d: got %h resp %b lat %0d expected %h / 00 / 1",
                 i, d, r, lat, 32'(i + 1));
      end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, lat, r);
    axi_write(5'h04, 32'h0000_00AA, 4'h1, lat, r);
    axi_read(5'h04, d, r, lat);
    tests++;
    if (d !== 32'hFFFF_FFAA) begin
      fails++;
      $display("FAIL strobe_data1: got %h expected ffffffaa", d);
    end
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, lat, r);
    axi_read(5'h10, d, r, lat);
    tests++;
    if (d !== 32'h0000_000F) begin
      fails++;
      $display("FAIL en_unused_bits: got %h expected 0000000f", d);
    end
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, lat, r);
    tests++;
    if (r !== 2'b00 || lat !== 1) begin
      fails++;
      $display("FAIL ro_write_resp: bresp %b lat %0d expected 00 / 1", r, lat);
    end
    axi_read(5'h18, d, r, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL ro_raw_unchanged: got %h expected 00000000", d);
    end
  endtask

  task automatic test_split_write();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          early;
    s_axi_awaddr  = 5'h08;
    s_axi_awvalid = 1'b1;
    s_axi_bready  = 1'b0;
    tick();
    s_axi_awvalid = 1'b0;
    tests++;
    if ({s_axi_awready, s_axi_wready} !== 2'b01) begin
      fails++;
      $display("FAIL split_aw_held: awready,wready=%b expected 01", {s_axi_awready, s_axi_wready});
    end
    early = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_axi_bvalid) early++;
      tick();
    end
    s_axi_wdata  = 32'h0000_5A5A;
    s_axi_wstrb  = 4'hF;
    s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    tests++;
    if (early !== 0 || s_axi_bvalid !== 1'b1) begin
      fails++;
      $display("FAIL split_bvalid_rise: early=%0d bvalid=%b expected 0 / 1", early, s_axi_bvalid);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
        fails++;
        $display("FAIL split_resp_hold%0d: bvalid,awready,wready=%b expected 100",
                 i, {s_axi_bvalid, s_axi_awready, s_axi_wready});
      end
      tick();
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    tests++;
    if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
      fails++;
      $display("FAIL split_resp_done: bvalid,awready,wready=%b expected 011",
               {s_axi_bvalid, s_axi_awready, s_axi_wready});
    end
    axi_read(5'h08, d, r, lat);
    tests++;
    if (d !== 32'h0000_5A5A) begin
      fails++;
      $display("FAIL split_readback: got %h expected 00005a5a", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;
    axi_write(5'h10, 32'h5, 4'hF, lat, r);
    irq_src = 4'b0011;
    n = 0;
    while (!irq && n < 8) begin
      tick();
      n++;
    end
    tests++;
    if (irq !== 1'b1 || n < 3 || n > 5) begin
      fails++;
      $display("FAIL irq_latency: irq=%b after %0d cycles expected 1 within 3..5", irq, n);
    end
    axi_read(5'h18, d, r, lat);
    tests++;
    if (d !== 32'h3) begin
      fails++;
      $display("FAIL irq_raw_high: got %h expected 00000003", d);
    end
    irq_src = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    axi_read(5'h14, d, r, lat);
    tests++;
    if (d !== 32'h3) begin
      fails++;
      $display("FAIL irq_status: got %h expected 00000003", d);
    end
    axi_read(5'h1C, d, r, lat);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL irq_pend: got %h expected 00000001", d);
    end
    axi_write(5'h14, 32'h1, 4'hF, lat, r);
    tick();
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_w1c_fall: irq=%b expected 0", irq);
    end
    axi_read(5'h14, d, r, lat);
    tests++;
    if (d !== 32'h2) begin
      fails++;
      $display("FAIL irq_status_after_w1c: got %h expected 00000002", d);
    end
    axi_write(5'h14, 32'h2, 4'h0, lat, r);
    axi_read(5'h14, d, r, lat);
    tests++;
    if (d !== 32'h2) begin
      fails++;
      $display("FAIL w1c_no_strobe: got %h expected 00000002", d);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    irq_src[2] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    irq_src[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    axi_read(5'h14, d, r, lat);
    tests++;
    if (d !== 32'h6) begin
      fails++;
      $display("FAIL race_pre_status: got %h expected 00000006", d);
    end
    // edge at sync output lines up with the commit cycle of the W1C below
    irq_src[2] = 1'b1;
    tick();
    s_axi_awaddr  = 5'h14;
    s_axi_wdata   = 32'h4;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    tests++;
    if (s_axi_bvalid !== 1'b1) begin
      fails++;
      $display("FAIL race_bvalid: got %b expected 1", s_axi_bvalid);
    end
    tick();
    s_axi_bready = 1'b0;
    axi_read(5'h14, d, r, lat);
    tests++;
    if (d !== 32'h6) begin
      fails++;
      $display("FAIL race_set_wins: got %h expected 00000006", d);
    end
    irq_src[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    axi_write(5'h14, 32'h4, 4'hF, lat, r);
    axi_read(5'h14, d, r, lat);
    tests++;
    if (d !== 32'h2) begin
      fails++;
      $display("FAIL race_plain_clear: got %h expected 00000002", d);
    end
  endtask

  task automatic test_back_to_back();
    int   cnt;
    logic data_ok;
    s_axi_araddr  = 5'h00;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    cnt = 0;
    data_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (s_axi_rvalid) begin
        cnt++;
        if (s_axi_rdata !== 32'h1) data_ok = 1'b0;
      end
      tick();
    end
    s_axi_arvalid = 1'b0;
    tick();
    s_axi_rready = 1'b0;
    tests++;
    if (cnt !== 5 || data_ok !== 1'b1) begin
      fails++;
      $display("FAIL b2b_reads: %0d beats data_ok=%b expected 5 / 1", cnt, data_ok);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    axi_write(5'h10, 32'h2, 4'hF, lat, r);
    tick();
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL inflight_irq_pre: got %b expected 1", irq);
    end
    s_axi_araddr  = 5'h00;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_awaddr  = 5'h0C;
    s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    tests++;
    if ({s_axi_rvalid, s_axi_awready} !== 2'b10) begin
      fails++;
      $display("FAIL inflight_pre: rvalid,awready=%b expected 10", {s_axi_rvalid, s_axi_awready});
    end
    #2;
    ARESET = 1'b1;
    #1;
    tests++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, irq} !== 6'b111000
        || s_axi_rdata !== 32'h0) begin
      fails++;
      $display("FAIL inflight_reset: rdy/valid/irq=%b rdata=%h expected 111000 / 00000000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, irq},
               s_axi_rdata);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    tick();
    axi_write(5'h0C, 32'h0000_1234, 4'hF, lat, r);
    tests++;
    if (lat !== 1 || r !== 2'b00) begin
      fails++;
      $display("FAIL post_reset_write: lat %0d bresp %b expected 1 / 00", lat, r);
    end
    axi_read(5'h0C, d, r, lat);
    tests++;
    if (d !== 32'h0000_1234 || lat !== 1) begin
      fails++;
      $display("FAIL post_reset_read: got %h lat %0d expected 00001234 / 1", d, lat);
    end
    axi_read(5'h00, d, r, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL post_reset_data0: got %h expected 00000000", d);
    end
    axi_read(5'h14, d, r, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL post_reset_status: got %h expected 00000000", d);
    end
  endtask

  initial begin
    ARESET        = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    irq_src       = '0;
    test_reset();
    test_data_rw();
    test_strobe();
    test_split_write();
    test_irq();
    test_set_wins();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_irq_responder.md
# axil_irq_responder

AXI4-Lite slave responder for the interrupt example peripheral: it terminates register reads and writes issued by an AXI4-Lite master and raises a level interrupt to the processor. It holds four scratch data registers, an interrupt enable mask and a write-1-to-clear status register. Status bits are set by rising edges on asynchronous event inputs. It sits behind the interconnect as the peripheral's S00_AXI port and drives the peripheral's `irq` pin.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32, data bus width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 5, byte address width, decoding 8 word registers.
- `C_NUM_IRQ`, 4, number of event inputs, 1..32.
- `ACLK` in 1: sole clock; all logic is on the rising edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `s_axi_awaddr` in 5, `s_axi_awprot` in 3 (ignored), `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in 5, `s_axi_arprot` in 3 (ignored), `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `irq_src` in C_NUM_IRQ: asynchronous event inputs; a rising edge is an event.
- `irq` out 1: registered interrupt; high when any bit of (status & enable) is set.

## Operation
- Register map, decoded from address bits [4:2]:
  - 0x00–0x0C DATA0..3: read/write scratch registers.
  - 0x10 IRQ_EN: read/write, bits [C_NUM_IRQ-1:0].
  - 0x14 IRQ_STATUS: writing 1 clears a bit; writing 0 has no effect.
  - 0x18 IRQ_RAW: read-only; returns the synchronized `irq_src` levels.
  - 0x1C IRQ_PEND: read-only; returns status & enable.
- Unused register bits read 0. Writes to read-only registers are accepted with OKAY and have no effect.
- `wstrb` applies per byte to DATAn and IRQ_EN. For IRQ_STATUS, a strobe-disabled byte clears nothing.
- `bresp` and `rresp` are always 00 (OKAY).
- Event path:
  - Each `irq_src` bit passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected edge sets the status bit.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Write path states:
  - IDLE → accept AW and W independently into holding registers. `awready` is high while the address is not held; `wready` is high while the data is not held.
  - Both held → commit the write in one cycle, assert `bvalid`, go to RESP.
  - RESP → hold `bvalid` until `bready`, then return to IDLE. No AW or W is accepted while in RESP.
- Read path:
  - `arready` is high while `rvalid` is low.
  - An AR handshake captures the address and loads `rdata`, registered, with `rvalid` high on the next cycle.
  - `rvalid` and `rdata` are held stable until `rready`.
- Read and write paths are independent.
  - A read in the same cycle as a write commit returns the pre-write value.
- Reset clears all registers, holding flags and synchronizers.
  - An in-flight transaction is discarded and no response is issued.
  - A master must re-issue it after reset.

## Timing
- Reset values:
  - `awready`, `wready`, `arready` = 1.
  - `bvalid`, `rvalid`, `irq` = 0.
  - `rdata` = 0, `bresp` = `rresp` = 00.
  - All registers = 0.
- Write, with AW and W presented together: handshake in cycle N, commit and `bvalid` high in N+1. Register visible to a read from N+2.
- AW and W separated by k cycles: `bvalid` rises one cycle after the later handshake.
- Read: AR handshake in cycle N, `rvalid` in N+1. Back-to-back reads complete once every 2 cycles with `rready` held high.
- Event to `irq`:
  - Edge at `irq_src` reaches the synchronizer output after 2 cycles.
  - Status sets one cycle later.
  - `irq` rises one cycle after that: 4 cycles, with ±1 cycle of asynchronous capture.
- W1C to `irq`:
  - Status clears in the commit cycle.
  - `irq` falls on the following edge, unless another event arrives in the meantime.
- `irq_src` pulses shorter than 2 ACLK periods may be missed; this is not required to be detected.

## Test plan
- Write DATA0..3 with 1, 2, 3, 4 via the AXI4-Lite master VIP, then read back -> 1, 2, 3, 4 with OKAY; `bvalid`/`rvalid` one cycle after the handshake.
- Write 0xFFFFFFFF to DATA1, then write 0x000000AA with wstrb=0001 -> DATA1 reads 0xFFFFFFAA.
- Present AW, then W 5 cycles later, with `bready` held low for 3 cycles -> single `bvalid` asserted until `bready`; `awready` and `wready` low during RESP.
- Set IRQ_EN=0x5, pulse `irq_src`[0] and [1] -> STATUS=0x3, PEND=0x1, `irq`=1 within 4±1 cycles. Write 0x1 to STATUS -> STATUS=0x2, `irq`=0.
- Rising edge on `irq_src`[2] in the same cycle as a W1C of bit 2 -> STATUS bit 2 stays 1.
- Assert ARESET while `rvalid` is pending and an AW is held -> all outputs at reset values immediately; the next write/read after release completes normally.
